// File: rtl/display_line_sequencer.sv
// display_line_sequencer: pops one buffered line at a time from the line FIFO,
// tracks the line within the frame, and handshakes frame completion with the display.
module display_line_sequencer #(
    parameter int WORDS_PER_LINE  = 16,
    parameter int LINES_PER_FRAME = 1024,
    parameter int LINE_GAP_CYCLES = 4,
    parameter int LINE_W          = 10
) (
    input  logic              fpga_clk,
    input  logic              reset_all,
    input  logic              enable_i,
    input  logic [4:0]        num_words_in_buffer,
    input  logic              frame_ack_i,
    output logic              rd_en_o,
    output logic              data_valid_o,
    output logic              line_start_o,
    output logic              line_end_o,
    output logic              frame_start_o,
    output logic [LINE_W-1:0] line_index_o,
    output logic              line_of_data_available,
    output logic              next_frame_rdy_o
);
    typedef enum logic [2:0] {IDLE, WAIT_LINE, READ, GAP, FRAME_DONE} state_t;

    state_t            state;
    state_t            end_state;
    logic [4:0]        word_cnt;
    logic [15:0]       gap_cnt;
    logic              last_line;
    logic [LINE_W-1:0] end_index;

    assign line_of_data_available = num_words_in_buffer >= 5'(WORDS_PER_LINE);
    assign last_line = line_index_o == LINE_W'(LINES_PER_FRAME - 1);

    // Where a finished line (after its gap) leads: end of frame, next line, or abandon.
    always_comb begin
        end_state = last_line ? FRAME_DONE : enable_i ? WAIT_LINE : IDLE;
        end_index = last_line ? line_index_o : enable_i ? line_index_o + LINE_W'(1) : '0;
    end

    always_ff @(posedge fpga_clk or posedge reset_all) begin
        if (reset_all) begin
            state            <= IDLE;
            word_cnt         <= '0;
            gap_cnt          <= '0;
            rd_en_o          <= 1'b0;
            data_valid_o     <= 1'b0;
            line_start_o     <= 1'b0;
            line_end_o       <= 1'b0;
            frame_start_o    <= 1'b0;
            line_index_o     <= '0;
            next_frame_rdy_o <= 1'b0;
        end else begin
            line_start_o  <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            data_valid_o  <= rd_en_o;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state        <= WAIT_LINE;
                        line_index_o <= '0;
                    end
                end
                WAIT_LINE: begin
                    if (!enable_i) begin
                        state        <= IDLE;
                        line_index_o <= '0;
                    end else if (line_of_data_available) begin
                        state         <= READ;
                        rd_en_o       <= 1'b1;
                        word_cnt      <= 5'd1;
                        line_start_o  <= 1'b1;
                        frame_start_o <= line_index_o == '0;
                        line_end_o    <= WORDS_PER_LINE == 1;
                    end
                end
                READ: begin
                    if (word_cnt == 5'(WORDS_PER_LINE)) begin
                        rd_en_o <= 1'b0;
                        gap_cnt <= '0;
                        if (LINE_GAP_CYCLES == 0) begin
                            state            <= end_state;
                            line_index_o     <= end_index;
                            next_frame_rdy_o <= last_line;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        word_cnt   <= word_cnt + 5'd1;
                        line_end_o <= word_cnt + 5'd1 == 5'(WORDS_PER_LINE);
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'(LINE_GAP_CYCLES - 1)) begin
                        state            <= end_state;
                        line_index_o     <= end_index;
                        next_frame_rdy_o <= last_line;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                FRAME_DONE: begin
                    if (frame_ack_i) begin
                        next_frame_rdy_o <= 1'b0;
                        line_index_o     <= '0;
                        state            <= enable_i ? WAIT_LINE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_line_sequencer.sv
// tb_display_line_sequencer: directed checks of line/frame sequencing on two configurations
// (4 words, 3 lines, gap 2) and (1 word, 2 lines, gap 0).
module tb_display_line_sequencer;
    logic       fpga_clk = 1'b0;
    logic       reset_all;
    logic       a_en, a_ack, b_en, b_ack;
    logic [4:0] a_lvl, b_lvl;
    logic       a_rd, a_dv, a_ls, a_le, a_fs, a_avail, a_rdy;
    logic       b_rd, b_dv, b_ls, b_le, b_fs, b_avail, b_rdy;
    logic [9:0] a_idx, b_idx;
    logic [31:0] rd_v, dv_v, ls_v, le_v, fs_v, rdy_v;
    logic [31:0] brd_v, bdv_v, bls_v, ble_v, bfs_v, brdy_v;
    logic [9:0]  idx_v [32];
    logic [9:0]  bidx_v [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 fpga_clk = ~fpga_clk;

    display_line_sequencer #(.WORDS_PER_LINE(4), .LINES_PER_FRAME(3), .LINE_GAP_CYCLES(2), .LINE_W(10)) u_a (
        .fpga_clk(fpga_clk), .reset_all(reset_all), .enable_i(a_en), .num_words_in_buffer(a_lvl),
        .frame_ack_i(a_ack), .rd_en_o(a_rd), .data_valid_o(a_dv), .line_start_o(a_ls),
        .line_end_o(a_le), .frame_start_o(a_fs), .line_index_o(a_idx),
        .line_of_data_available(a_avail), .next_frame_rdy_o(a_rdy));

    display_line_sequencer #(.WORDS_PER_LINE(1), .LINES_PER_FRAME(2), .LINE_GAP_CYCLES(0), .LINE_W(10)) u_b (
        .fpga_clk(fpga_clk), .reset_all(reset_all), .enable_i(b_en), .num_words_in_buffer(b_lvl),
        .frame_ack_i(b_ack), .rd_en_o(b_rd), .data_valid_o(b_dv), .line_start_o(b_ls),
        .line_end_o(b_le), .frame_start_o(b_fs), .line_index_o(b_idx),
        .line_of_data_available(b_avail), .next_frame_rdy_o(b_rdy));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n cycles, recording outputs of both instances 1 time unit after each edge.
    task automatic run(input int n);
        rd_v = '0; dv_v = '0; ls_v = '0; le_v = '0; fs_v = '0; rdy_v = '0;
        brd_v = '0; bdv_v = '0; bls_v = '0; ble_v = '0; bfs_v = '0; brdy_v = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge fpga_clk);
            #1;
            rd_v[i] = a_rd; dv_v[i] = a_dv; ls_v[i] = a_ls; le_v[i] = a_le;
            fs_v[i] = a_fs; rdy_v[i] = a_rdy; idx_v[i] = a_idx;
            brd_v[i] = b_rd; bdv_v[i] = b_dv; bls_v[i] = b_ls; ble_v[i] = b_le;
            bfs_v[i] = b_fs; brdy_v[i] = b_rdy; bidx_v[i] = b_idx;
        end
    endtask

    initial begin
        reset_all = 1'b1;
        a_en = 1'b0; a_ack = 1'b0; a_lvl = 5'd0;
        b_en = 1'b0; b_ack = 1'b0; b_lvl = 5'd0;
        run(2);
        chk("rst_rd", a_rd, 0);
        chk("rst_dv", a_dv, 0);
        chk("rst_ls_le_fs", {a_ls, a_le, a_fs}, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_rdy", a_rdy, 0);
        reset_all = 1'b0;
        a_en = 1'b1; a_lvl = 5'd3; a_ack = 1'b1;
        run(6);
        chk("lvl3_no_rd", rd_v[5:0], 0);
        chk("avail_lo", a_avail, 0);
        chk("early_ack_ignored", rdy_v[5:0], 0);
        a_ack = 1'b0; a_lvl = 5'd4;
        #1;
        chk("avail_hi", a_avail, 1);
        a_lvl = 5'd31;
        run(24);
        chk("frame_rd", rd_v[23:0], 24'h03C78F);
        chk("frame_dv", dv_v[23:0], 24'h078F1E);
        chk("frame_ls", ls_v[23:0], 24'h004081);
        chk("frame_le", le_v[23:0], 24'h020408);
        chk("frame_fs", fs_v[23:0], 24'h000001);
        chk("frame_rdy", rdy_v[23:0], 24'hF00000);
        chk("idx_l0", idx_v[0], 0);
        chk("idx_l1", idx_v[7], 1);
        chk("idx_l2", idx_v[14], 2);
        chk("idx_hold", idx_v[23], 2);
        a_ack = 1'b1;
        run(1);
        chk("ack_rdy_clr", rdy_v[0], 0);
        chk("ack_idx0", idx_v[0], 0);
        a_ack = 1'b0;
        run(1);
        chk("nf_rd_ls_fs", {rd_v[0], ls_v[0], fs_v[0]}, 3'b111);
        chk("nf_idx", idx_v[0], 0);
        run(8);
        chk("nf_rd_a", rd_v[7:0], 8'hC7);
        chk("nf_idx1", idx_v[6], 1);
        a_en = 1'b0;
        run(10);
        chk("drop_rd", rd_v[9:0], 10'h003);
        chk("drop_le", le_v[9:0], 10'h002);
        chk("drop_gap_idx", idx_v[3], 1);
        chk("drop_idle_idx", idx_v[4], 0);
        a_en = 1'b1;
        run(3);
        chk("pre_rst_rd", rd_v[2:0], 3'b110);
        chk("pre_rst_fs", fs_v[2:0], 3'b010);
        reset_all = 1'b1;
        #1;
        chk("arst_rd", a_rd, 0);
        chk("arst_dv", a_dv, 0);
        chk("arst_ls_le_fs", {a_ls, a_le, a_fs}, 0);
        chk("arst_idx_rdy", {a_idx, a_rdy}, 0);
        run(2);
        reset_all = 1'b0;
        run(3);
        chk("post_rst_rd", rd_v[2:0], 3'b110);
        chk("post_rst_fs", fs_v[2:0], 3'b010);
        chk("post_rst_idx", idx_v[1], 0);
        a_en = 1'b0;
        b_en = 1'b1; b_lvl = 5'd1;
        run(6);
        chk("b_rd", brd_v[5:0], 6'h0A);
        chk("b_dv", bdv_v[5:0], 6'h14);
        chk("b_ls", bls_v[5:0], 6'h0A);
        chk("b_le", ble_v[5:0], 6'h0A);
        chk("b_fs", bfs_v[5:0], 6'h02);
        chk("b_rdy", brdy_v[5:0], 6'h30);
        chk("b_idx1", bidx_v[3], 1);
        b_ack = 1'b1;
        run(1);
        chk("b_ack_clr", {brdy_v[0], bidx_v[0]}, 0);
        b_ack = 1'b0;
        run(1);
        chk("b_nf", {brd_v[0], bls_v[0], ble_v[0], bfs_v[0]}, 4'hF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
